// File: rtl/pmp_checker_pkg.sv
// Shared PMP types: privilege levels, address-matching modes, permission bits
// and the 8-bit pmpcfg layout.
package pmp_checker_pkg;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_M = 2'b11
   } priv_lvl_t;

   typedef enum logic [1:0] {
      PMP_OFF   = 2'b00,
      PMP_TOR   = 2'b01,
      PMP_NA4   = 2'b10,
      PMP_NAPOT = 2'b11
   } pmp_addr_mode_t;

   typedef struct packed {
      logic x;
      logic w;
      logic r;
   } pmp_access_t;

   typedef struct packed {
      logic           locked;
      logic [1:0]     reserved;
      pmp_addr_mode_t addr_mode;
      pmp_access_t    access;
   } pmpcfg_t;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE 0 counts trailing zeros, MODE 1 leading
// zeros; empty_o flags an all-zero input (cnt_o is then 0).
module lzc #(
   parameter int unsigned WIDTH     = 2,
   parameter bit          MODE      = 1'b0,
   parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0]     in_i,
   output logic [CNT_WIDTH-1:0] cnt_o,
   output logic                 empty_o
);

   logic [WIDTH-1:0] in_ordered;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_order
      if (MODE) begin : gen_rev
         assign in_ordered[gi] = in_i[WIDTH-1-gi];
      end else begin : gen_fwd
         assign in_ordered[gi] = in_i[gi];
      end
   end

   always_comb begin
      cnt_o   = '0;
      empty_o = 1'b1;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (empty_o && in_ordered[i]) begin
            cnt_o   = i[CNT_WIDTH-1:0];
            empty_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/pmp_entry_match.sv
// Combinational address matcher for a single PMP entry (OFF/TOR/NA4/NAPOT).
module pmp_entry_match
   import pmp_checker_pkg::*;
#(
   parameter int unsigned PLEN    = 56,
   parameter int unsigned PMP_LEN = 54
) (
   input  logic [PLEN-1:0]    addr_i,
   input  logic [PMP_LEN-1:0] conf_addr_i,
   input  logic [PMP_LEN-1:0] conf_addr_prev_i,
   input  pmp_addr_mode_t     mode_i,
   output logic               match_o
);

   localparam int unsigned TW = (PMP_LEN > 1) ? $clog2(PMP_LEN) : 1;
   localparam logic [TW:0] NAPOT_MIN_SIZE = 3;

   logic [PLEN-1:0] cur_addr;
   logic [PLEN-1:0] prev_addr;
   logic [PLEN-1:0] napot_mask;
   logic [TW-1:0]   trail_ones;
   logic [TW:0]     napot_size;
   logic            conf_all_ones;

   assign cur_addr  = {conf_addr_i, 2'b00};
   assign prev_addr = {conf_addr_prev_i, 2'b00};

   // Trailing ones of conf_addr are the trailing zeros of its complement.
   lzc #(
      .WIDTH    (PMP_LEN),
      .MODE     (1'b0),
      .CNT_WIDTH(TW)
   ) i_trail_ones (
      .in_i   (~conf_addr_i),
      .cnt_o  (trail_ones),
      .empty_o(conf_all_ones)
   );

   assign napot_size = {1'b0, trail_ones} + NAPOT_MIN_SIZE;
   assign napot_mask = {PLEN{1'b1}} << napot_size;

   always_comb begin
      match_o = 1'b0;
      case (mode_i)
         PMP_TOR:   match_o = (addr_i >= prev_addr) && (addr_i < cur_addr);
         PMP_NA4:   match_o = (addr_i[PLEN-1:2] == conf_addr_i);
         PMP_NAPOT: match_o = conf_all_ones ||
                              ((addr_i & napot_mask) == (cur_addr & napot_mask));
         default:   match_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/pmp_checker.sv
// Multi-entry PMP checker: two-stage elastic pipeline (S0 captures the request,
// S1 holds the registered verdict of the lowest-index matching entry).
module pmp_checker
   import pmp_checker_pkg::*;
#(
   parameter  int unsigned PLEN       = 56,
   parameter  int unsigned PMP_LEN    = 54,
   parameter  int unsigned NR_ENTRIES = 16,
   parameter  int unsigned ID_WIDTH   = 4,
   localparam int unsigned NE         = (NR_ENTRIES > 0) ? NR_ENTRIES : 1,
   localparam int unsigned EW         = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic [PLEN-1:0]            req_addr_i,
   input  pmp_access_t                req_access_i,
   input  priv_lvl_t                  req_priv_i,
   input  logic [ID_WIDTH-1:0]        req_id_i,
   input  logic [NE-1:0][PMP_LEN-1:0] conf_addr_i,
   input  pmpcfg_t [NE-1:0]           conf_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic                       rsp_allow_o,
   output logic                       rsp_match_o,
   output logic [EW-1:0]              rsp_entry_o,
   output logic [ID_WIDTH-1:0]        rsp_id_o
);

   logic                s0_valid_q, s0_valid_d;
   logic [PLEN-1:0]     s0_addr_q;
   pmp_access_t         s0_access_q;
   priv_lvl_t           s0_priv_q;
   logic [ID_WIDTH-1:0] s0_id_q;

   logic                s1_valid_q, s1_valid_d;
   logic                s1_allow_q, s1_allow_d;
   logic                s1_match_q, s1_match_d;
   logic [EW-1:0]       s1_entry_q, s1_entry_d;
   logic [ID_WIDTH-1:0] s1_id_q;

   logic                s1_ready;
   logic                req_accept;
   logic                s0_to_s1;
   logic [NE-1:0]       entry_match;
   pmpcfg_t             sel_cfg;
   logic                unused_reserved;

   // Handshake chain is combinational so a full pipeline can accept and drain
   // in the same cycle.
   assign s1_ready    = !s1_valid_q || rsp_ready_i;
   assign req_ready_o = !s0_valid_q || s1_ready;
   assign req_accept  = req_valid_i && req_ready_o;
   assign s0_to_s1    = s0_valid_q && s1_ready;

   always_comb begin
      s0_valid_d = s0_valid_q;
      if (req_accept) begin
         s0_valid_d = 1'b1;
      end else if (s0_to_s1) begin
         s0_valid_d = 1'b0;
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      if (s0_to_s1) begin
         s1_valid_d = 1'b1;
      end else if (rsp_ready_i) begin
         s1_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s0_valid_q  <= 1'b0;
         s0_addr_q   <= '0;
         s0_access_q <= '0;
         s0_priv_q   <= PRIV_LVL_U;
         s0_id_q     <= '0;
      end else begin
         s0_valid_q <= s0_valid_d;
         if (req_accept) begin
            s0_addr_q   <= req_addr_i;
            s0_access_q <= req_access_i;
            s0_priv_q   <= req_priv_i;
            s0_id_q     <= req_id_i;
         end
      end
   end

   for (genvar gi = 0; gi < NE; gi++) begin : gen_entry
      logic [PMP_LEN-1:0] prev_conf_addr;
      logic               raw_match;

      // TOR lower bound is the previous pmpaddr whatever that entry's mode is.
      if (gi == 0) begin : gen_first
         assign prev_conf_addr = '0;
      end else begin : gen_rest
         assign prev_conf_addr = conf_addr_i[gi-1];
      end

      pmp_entry_match #(
         .PLEN   (PLEN),
         .PMP_LEN(PMP_LEN)
      ) i_entry_match (
         .addr_i          (s0_addr_q),
         .conf_addr_i     (conf_addr_i[gi]),
         .conf_addr_prev_i(prev_conf_addr),
         .mode_i          (conf_i[gi].addr_mode),
         .match_o         (raw_match)
      );

      assign entry_match[gi] = (NR_ENTRIES != 0) && raw_match;
   end

   // Walk from the top so the lowest matching index wins.
   always_comb begin
      s1_match_d = 1'b0;
      s1_entry_d = '0;
      sel_cfg    = '0;
      for (int i = NE - 1; i >= 0; i--) begin
         if (entry_match[i]) begin
            s1_match_d = 1'b1;
            s1_entry_d = i[EW-1:0];
            sel_cfg    = conf_i[i];
         end
      end
   end

   always_comb begin
      s1_allow_d = 1'b0;
      if (s1_match_d) begin
         s1_allow_d = ((s0_priv_q == PRIV_LVL_M) && !sel_cfg.locked) ||
                      (|(s0_access_q & sel_cfg.access));
      end else begin
         s1_allow_d = (s0_priv_q == PRIV_LVL_M) || (NR_ENTRIES == 0);
      end
   end

   always_comb begin
      unused_reserved = 1'b0;
      for (int i = 0; i < NE; i++) begin
         unused_reserved = unused_reserved ^ (^conf_i[i].reserved);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s1_allow_q <= 1'b0;
         s1_match_q <= 1'b0;
         s1_entry_q <= '0;
         s1_id_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (s0_to_s1) begin
            s1_allow_q <= s1_allow_d;
            s1_match_q <= s1_match_d;
            s1_entry_q <= s1_entry_d;
            s1_id_q    <= s0_id_q;
         end
      end
   end

   assign rsp_valid_o = s1_valid_q;
   assign rsp_allow_o = s1_allow_q;
   assign rsp_match_o = s1_match_q;
   assign rsp_entry_o = s1_entry_q;
   assign rsp_id_o    = s1_id_q;

endmodule

// File: tb/tb_pmp_checker.sv
// Directed and randomized checks of pmp_checker against a first-match
// arithmetic reference model of the PMP rules.
module tb_pmp_checker;
   import pmp_checker_pkg::*;

   localparam int unsigned PLEN    = 56;
   localparam int unsigned PMP_LEN = 54;
   localparam int unsigned NR      = 16;
   localparam int unsigned IDW     = 4;

   typedef struct {
      logic [3:0] id;
      logic       m;
      logic [3:0] e;
      logic       a;
   } exp_t;

   logic                      clk_i = 1'b0;
   logic                      rst_ni = 1'b0;
   logic                      req_valid = 1'b0;
   logic                      req_ready_o;
   logic [PLEN-1:0]           req_addr = '0;
   logic [2:0]                req_access = 3'b001;
   priv_lvl_t                 req_priv = PRIV_LVL_U;
   logic [IDW-1:0]            req_id = '0;
   logic [NR-1:0][PMP_LEN-1:0] conf_addr = '0;
   pmpcfg_t [NR-1:0]          conf = '0;
   logic                      rsp_valid_o;
   logic                      rsp_ready = 1'b1;
   logic                      rsp_allow_o;
   logic                      rsp_match_o;
   logic [3:0]                rsp_entry_o;
   logic [IDW-1:0]            rsp_id_o;

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   logic [3:0] next_id = '0;

   pmp_checker #(
      .PLEN      (PLEN),
      .PMP_LEN   (PMP_LEN),
      .NR_ENTRIES(NR),
      .ID_WIDTH  (IDW)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr),
      .req_access_i(req_access),
      .req_priv_i  (req_priv),
      .req_id_i    (req_id),
      .conf_addr_i (conf_addr),
      .conf_i      (conf),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready),
      .rsp_allow_o (rsp_allow_o),
      .rsp_match_o (rsp_match_o),
      .rsp_entry_o (rsp_entry_o),
      .rsp_id_o    (rsp_id_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic pmpcfg_t mk_cfg(input logic lock, input pmp_addr_mode_t md,
                                      input logic [2:0] acc);
      pmpcfg_t c;
      c.locked    = lock;
      c.reserved  = 2'b00;
      c.addr_mode = md;
      c.access    = acc;
      return c;
   endfunction

   // Reference: scan entries in index order, first hit decides.
   function automatic exp_t model(input logic [PLEN-1:0] addr, input logic [2:0] acc,
                                  input priv_lvl_t priv, input logic [3:0] id);
      exp_t r;
      longint unsigned a, lo, hi;
      int t;
      bit hit;
      r.id = id;
      r.m  = 1'b0;
      r.e  = 4'd0;
      r.a  = (priv == PRIV_LVL_M);
      a    = 64'(addr);
      for (int i = 0; i < NR && !r.m; i++) begin
         hi  = 64'(conf_addr[i]) * 4;
         lo  = (i == 0) ? 64'd0 : 64'(conf_addr[i-1]) * 4;
         hit = 1'b0;
         case (conf[i].addr_mode)
            PMP_TOR: hit = (a >= lo) && (a < hi);
            PMP_NA4: hit = ((a >> 2) == 64'(conf_addr[i]));
            PMP_NAPOT: begin
               t = 0;
               while (t < PMP_LEN && conf_addr[i][t]) t++;
               hit = (t == PMP_LEN) || ((a >> (t + 3)) == (hi >> (t + 3)));
            end
            default: hit = 1'b0;
         endcase
         if (hit) begin
            r.m = 1'b1;
            r.e = 4'(i);
            r.a = ((priv == PRIV_LVL_M) && !conf[i].locked) || ((acc & conf[i].access) != 3'b000);
         end
      end
      return r;
   endfunction

   task automatic clear_config();
      conf_addr = '0;
      conf      = '0;
   endtask

   // One request with rsp_ready high; checks 2-cycle latency and the verdict.
   task automatic send_one(input string tag, input logic [PLEN-1:0] addr, input logic [2:0] acc,
                           input priv_lvl_t priv, input logic [3:0] id,
                           input logic em, input logic [3:0] ee, input logic ea);
      int lat;
      req_valid  = 1'b1;
      req_addr   = addr;
      req_access = acc;
      req_priv   = priv;
      req_id     = id;
      rsp_ready  = 1'b1;
      #2;
      chk({tag, ".req_ready"}, 64'(req_ready_o), 64'(1));
      tick();
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid_o && lat < 8) begin
         tick();
         lat++;
      end
      chk({tag, ".latency"}, 64'(lat), 64'(2));
      chk({tag, ".match"}, 64'(rsp_match_o), 64'(em));
      chk({tag, ".entry"}, 64'(rsp_entry_o), 64'(ee));
      chk({tag, ".allow"}, 64'(rsp_allow_o), 64'(ea));
      chk({tag, ".id"}, 64'(rsp_id_o), 64'(id));
      tick();
   endtask

   // Random-phase cycle: score a drain against the queue, queue an acceptance.
   task automatic rcycle();
      exp_t e;
      #2;
      if (rsp_valid_o && rsp_ready) begin
         chk("rand.rsp_expected", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rand.id", 64'(rsp_id_o), 64'(e.id));
            chk("rand.match", 64'(rsp_match_o), 64'(e.m));
            chk("rand.entry", 64'(rsp_entry_o), 64'(e.e));
            chk("rand.allow", 64'(rsp_allow_o), 64'(e.a));
         end
      end
      if (req_valid && req_ready_o) begin
         exp_q.push_back(model(req_addr, req_access, req_priv, req_id));
         next_id = next_id + 4'd1;
      end
      tick();
   endtask

   task automatic rand_config();
      for (int i = 0; i < NR; i++) begin
         logic [PMP_LEN-1:0] base;
         logic [1:0]         md;
         int                 k;
         base = PMP_LEN'($urandom_range(0, 32'h3FF));
         md   = 2'($urandom_range(0, 3));
         if (md == 2'd3) begin
            k    = $urandom_range(0, 8);
            base = ((base >> (k + 1)) << (k + 1)) | ((PMP_LEN'(1) << k) - PMP_LEN'(1));
         end
         conf_addr[i] = base;
         conf[i] = mk_cfg($urandom_range(0, 3) == 0, pmp_addr_mode_t'(md),
                          3'($urandom_range(0, 7)));
      end
   endtask

   initial begin
      // Reset state
      #2;
      chk("reset.rsp_valid", 64'(rsp_valid_o), 64'(0));
      chk("reset.req_ready", 64'(req_ready_o), 64'(1));
      chk("reset.rsp_allow", 64'(rsp_allow_o), 64'(0));
      chk("reset.rsp_id", 64'(rsp_id_o), 64'(0));
      tick();
      tick();
      rst_ni = 1'b1;
      tick();

      // TOR entry 0 without R, U-mode read just below the top
      clear_config();
      conf_addr[0] = 54'h400;
      conf[0]      = mk_cfg(1'b0, PMP_TOR, 3'b000);
      send_one("tor_u_read", 56'hFFC, 3'b001, PRIV_LVL_U, 4'h3, 1'b1, 4'd0, 1'b0);
      send_one("tor_top_excl", 56'h1000, 3'b001, PRIV_LVL_U, 4'h4, 1'b0, 4'd0, 1'b0);

      // Overlapping NAPOT (entry 2, R) and NA4 (entry 5, RW): lowest wins
      clear_config();
      conf_addr[2] = 54'h2000_01FF;
      conf[2]      = mk_cfg(1'b0, PMP_NAPOT, 3'b001);
      conf_addr[5] = 54'h2000_0000;
      conf[5]      = mk_cfg(1'b0, PMP_NA4, 3'b011);
      send_one("prio_u_write", 56'h8000_0000, 3'b010, PRIV_LVL_U, 4'h5, 1'b1, 4'd2, 1'b0);

      // No match: M allowed, S denied
      clear_config();
      send_one("nomatch_m", 56'h1234, 3'b010, PRIV_LVL_M, 4'h6, 1'b0, 4'd0, 1'b1);
      send_one("nomatch_s", 56'h1234, 3'b010, PRIV_LVL_S, 4'h7, 1'b0, 4'd0, 1'b0);

      // Lock semantics on entry 1 (NA4, R only)
      conf_addr[1] = 54'h100;
      conf[1]      = mk_cfg(1'b1, PMP_NA4, 3'b001);
      send_one("locked_m_write", 56'h400, 3'b010, PRIV_LVL_M, 4'h8, 1'b1, 4'd1, 1'b0);
      conf[1]      = mk_cfg(1'b0, PMP_NA4, 3'b001);
      send_one("unlocked_m_write", 56'h400, 3'b010, PRIV_LVL_M, 4'h9, 1'b1, 4'd1, 1'b1);

      // Backpressure: two accepted, third stalls for 3 cycles
      rsp_ready  = 1'b0;
      req_valid  = 1'b1;
      req_addr   = 56'h400;
      req_access = 3'b001;
      req_priv   = PRIV_LVL_U;
      req_id     = 4'h1;
      #2;
      chk("bp.accept1", 64'(req_ready_o), 64'(1));
      tick();
      req_id = 4'h2;
      #2;
      chk("bp.accept2", 64'(req_ready_o), 64'(1));
      tick();
      req_id = 4'h3;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) conf[1] = '0;
         if (k == 2) conf[1] = mk_cfg(1'b0, PMP_NA4, 3'b001);
         #2;
         chk("bp.stall_ready", 64'(req_ready_o), 64'(0));
         chk("bp.hold_valid", 64'(rsp_valid_o), 64'(1));
         chk("bp.hold_id", 64'(rsp_id_o), 64'(1));
         chk("bp.hold_match", 64'(rsp_match_o), 64'(1));
         chk("bp.hold_allow", 64'(rsp_allow_o), 64'(1));
         tick();
      end
      rsp_ready = 1'b1;
      #2;
      chk("bp.accept3", 64'(req_ready_o), 64'(1));
      chk("bp.rsp1_id", 64'(rsp_id_o), 64'(1));
      tick();
      req_valid = 1'b0;
      #2;
      chk("bp.rsp2_valid", 64'(rsp_valid_o), 64'(1));
      chk("bp.rsp2_id", 64'(rsp_id_o), 64'(2));
      chk("bp.rsp2_allow", 64'(rsp_allow_o), 64'(1));
      tick();
      #2;
      chk("bp.rsp3_valid", 64'(rsp_valid_o), 64'(1));
      chk("bp.rsp3_id", 64'(rsp_id_o), 64'(3));
      tick();
      #2;
      chk("bp.empty", 64'(rsp_valid_o), 64'(0));
      tick();

      // Reset with two requests in flight
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_id    = 4'hA;
      tick();
      req_id = 4'hB;
      tick();
      req_valid = 1'b0;
      #2;
      chk("rst.pre_valid", 64'(rsp_valid_o), 64'(1));
      rst_ni = 1'b0;
      #1;
      chk("rst.async_valid", 64'(rsp_valid_o), 64'(0));
      chk("rst.async_ready", 64'(req_ready_o), 64'(1));
      chk("rst.async_id", 64'(rsp_id_o), 64'(0));
      tick();
      rst_ni    = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #2;
         chk("rst.no_stale", 64'(rsp_valid_o), 64'(0));
         tick();
      end

      // Randomized traffic, config held constant per batch
      for (int b = 0; b < 3; b++) begin
         rand_config();
         for (int c = 0; c < 150; c++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) req_addr = 56'({$urandom(), $urandom()});
            else req_addr = 56'($urandom_range(0, 32'h1FFF));
            req_access = 3'b001 << $urandom_range(0, 2);
            case ($urandom_range(0, 2))
               0:       req_priv = PRIV_LVL_U;
               1:       req_priv = PRIV_LVL_S;
               default: req_priv = PRIV_LVL_M;
            endcase
            req_id    = next_id;
            rsp_ready = ($urandom_range(0, 3) != 0);
            rcycle();
         end
         req_valid = 1'b0;
         rsp_ready = 1'b1;
         for (int c = 0; c < 6; c++) rcycle();
         chk("rand.drained", 64'(exp_q.size()), 64'(0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
